stepper_pulse_gen: RTL

Multi-channel, parametrised successor to the single-channel stepper controller FSM. Each channel accepts a step count and direction, then emits exactly that many STEP pulses of programmable high/low width, paced by the shared `clk_en` tick. It reports per-channel busy/done status to the motion sequencer. An optional signed position counter tracks accumulated steps per channel.

---
 rtl/stepper_pkg.sv | 24 ++
 rtl/stepper_channel.sv | 152 +++++++++++++++
 rtl/stepper_pulse_gen.sv | 66 ++++++
 3 files changed

// File: rtl/stepper_pkg.sv
// Shared types and default parameters for the multi-channel stepper pulse generator.
package stepper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } stepper_state_t;

    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_COUNT_W    = 16;
    localparam int DEF_HIGH_TICKS = 4;
    localparam int DEF_LOW_TICKS  = 4;
    localparam int DEF_POS_W      = 24;

    // The phase counter only has to reach the longer phase length minus one.
    function automatic int tick_cnt_width(input int high_ticks, input int low_ticks);
        int longest;
        longest = (high_ticks > low_ticks) ? high_ticks : low_ticks;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/stepper_channel.sv
// One stepper channel: IDLE/SETUP/HIGH/LOW sequencer with remaining-step and phase counters.
// STEPPER_POSITION_EN adds a signed, wrapping position counter.
module stepper_channel
    import stepper_pkg::*;
#(
    parameter int COUNT_W    = DEF_COUNT_W,
    parameter int HIGH_TICKS = DEF_HIGH_TICKS,
    parameter int LOW_TICKS  = DEF_LOW_TICKS
`ifdef STEPPER_POSITION_EN
    ,
    parameter int POS_W      = DEF_POS_W
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clk_en,
    input  logic               trigger,
    input  logic [COUNT_W-1:0] num_steps,
    input  logic               dir_in,
    input  logic               abort,
    output logic               step,
    output logic               dir,
    output logic               busy,
    output logic               done
`ifdef STEPPER_POSITION_EN
    ,
    output logic signed [POS_W-1:0] position
`endif
);

    localparam int                TICK_W    = tick_cnt_width(HIGH_TICKS, LOW_TICKS);
    localparam logic [TICK_W-1:0] HIGH_LAST = TICK_W'(HIGH_TICKS - 1);
    localparam logic [TICK_W-1:0] LOW_LAST  = TICK_W'(LOW_TICKS - 1);

    stepper_state_t     state_r;
    logic [TICK_W-1:0]  tick_cnt_r;
    logic [COUNT_W-1:0] remaining_r;
    logic               step_r;
    logic               dir_r;
    logic               busy_r;
    logic               done_r;
    logic               low_end_s;
    logic               last_step_s;
    logic               pulse_start_s;

    assign low_end_s     = (state_r == LOW) && (tick_cnt_r == LOW_LAST);
    assign last_step_s   = (remaining_r == COUNT_W'(1));
    // A pulse starts on SETUP->HIGH or LOW->HIGH, unless abort takes the tick.
    assign pulse_start_s = clk_en && !abort &&
                           ((state_r == SETUP) || (low_end_s && !last_step_s));

    // Channel sequencer; done is cleared on every clk so it is one cycle wide even with gapped ticks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            tick_cnt_r  <= {TICK_W{1'b0}};
            remaining_r <= {COUNT_W{1'b0}};
            step_r      <= 1'b0;
            dir_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (clk_en) begin
                if (abort) begin
                    state_r    <= IDLE;
                    tick_cnt_r <= {TICK_W{1'b0}};
                    step_r     <= 1'b0;
                    busy_r     <= 1'b0;
                end else begin
                    case (state_r)
                        IDLE: begin
                            if (trigger) begin
                                remaining_r <= num_steps;
                                dir_r       <= dir_in;
                                if (num_steps != {COUNT_W{1'b0}}) begin
                                    state_r <= SETUP;
                                    busy_r  <= 1'b1;
                                end else begin
                                    done_r  <= 1'b1;
                                end
                            end
                        end
                        SETUP: begin
                            state_r    <= HIGH;
                            tick_cnt_r <= {TICK_W{1'b0}};
                            step_r     <= 1'b1;
                        end
                        HIGH: begin
                            if (tick_cnt_r == HIGH_LAST) begin
                                state_r    <= LOW;
                                tick_cnt_r <= {TICK_W{1'b0}};
                                step_r     <= 1'b0;
                            end else begin
                                tick_cnt_r <= tick_cnt_r + TICK_W'(1);
                            end
                        end
                        LOW: begin
                            if (low_end_s) begin
                                tick_cnt_r  <= {TICK_W{1'b0}};
                                remaining_r <= remaining_r - COUNT_W'(1);
                                if (last_step_s) begin
                                    state_r <= IDLE;
                                    busy_r  <= 1'b0;
                                    done_r  <= 1'b1;
                                end else begin
                                    state_r <= HIGH;
                                    step_r  <= 1'b1;
                                end
                            end else begin
                                tick_cnt_r <= tick_cnt_r + TICK_W'(1);
                            end
                        end
                        default: begin
                            state_r    <= IDLE;
                            tick_cnt_r <= {TICK_W{1'b0}};
                            step_r     <= 1'b0;
                            busy_r     <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign step = step_r;
    assign dir  = dir_r;
    assign busy = busy_r;
    assign done = done_r;

`ifdef STEPPER_POSITION_EN
    logic signed [POS_W-1:0] position_r;
    logic signed [POS_W-1:0] position_delta_s;

    // All-ones is -1, so a single adder covers both directions and wraps naturally.
    assign position_delta_s = dir_r ? POS_W'(1) : {POS_W{1'b1}};

    // Position counter advances once per started pulse, including pulses later truncated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            position_r <= {POS_W{1'b0}};
        end else if (pulse_start_s) begin
            position_r <= position_r + position_delta_s;
        end else begin
            position_r <= position_r;
        end
    end

    assign position = position_r;
`endif

endmodule

// File: rtl/stepper_pulse_gen.sv
// NUM_CH independent stepper channels sharing clk_en and abort.
// Define STEPPER_POSITION_EN to add the flattened signed position output.
module stepper_pulse_gen
    import stepper_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int COUNT_W    = DEF_COUNT_W,
    parameter int HIGH_TICKS = DEF_HIGH_TICKS,
    parameter int LOW_TICKS  = DEF_LOW_TICKS,
    parameter int POS_W      = DEF_POS_W
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clk_en,
    input  logic [NUM_CH-1:0]         trigger,
    input  logic [NUM_CH*COUNT_W-1:0] num_steps,
    input  logic [NUM_CH-1:0]         dir_in,
    input  logic                      abort,
    output logic [NUM_CH-1:0]         step,
    output logic [NUM_CH-1:0]         dir,
    output logic [NUM_CH-1:0]         busy,
    output logic [NUM_CH-1:0]         done,
    output logic                      all_idle
`ifdef STEPPER_POSITION_EN
    ,
    output logic [NUM_CH*POS_W-1:0]   position
`endif
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        stepper_channel #(
            .COUNT_W    (COUNT_W),
            .HIGH_TICKS (HIGH_TICKS),
            .LOW_TICKS  (LOW_TICKS)
`ifdef STEPPER_POSITION_EN
            ,
            .POS_W      (POS_W)
`endif
        ) u_channel (
            .clk       (clk),
            .reset_n   (reset_n),
            .clk_en    (clk_en),
            .trigger   (trigger[i]),
            .num_steps (num_steps[i*COUNT_W +: COUNT_W]),
            .dir_in    (dir_in[i]),
            .abort     (abort),
            .step      (step[i]),
            .dir       (dir[i]),
            .busy      (busy[i]),
            .done      (done[i])
`ifdef STEPPER_POSITION_EN
            ,
            .position  (position[i*POS_W +: POS_W])
`endif
        );
    end

`ifndef STEPPER_POSITION_EN
    // POS_W only sizes the position counters; keep it referenced when they are absent.
    if (POS_W < 1) begin : g_pos_w_unused
    end
`endif

    assign all_idle = ~|busy;

endmodule
